// File: rtl/addsub_pkg.sv
// ============================================================================
// Module   : addsub_pkg
// Brief    : Shared mode encodings and slice-geometry helpers for the adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package addsub_pkg;

  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= 8) && (width % stages == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_slice.sv
// ============================================================================
// Module   : addsub_slice
// Brief    : One carry-chain slice of the pipelined adder with its stage regs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module addsub_slice
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_res,
  output logic             out_valid,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_res
);

  localparam int C  = slice_width(WIDTH, STAGES);
  localparam int LO = IDX * C;
  localparam int HI = LO + C - 1;

  logic [C:0]       w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_zero;

  logic             r_valid;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;

  assign w_sum = {1'b0, in_a[HI:LO]} + {1'b0, in_b[HI:LO]} + {{C{1'b0}}, in_carry};

  // Lower result slices ride through unchanged; this slice overwrites its own field.
  always_comb begin
    w_res        = in_res;
    w_res[HI:LO] = w_sum[C-1:0];
  end

  // Zero is accumulated slice by slice; overflow is only consumed from the top slice.
  assign w_zero = in_zero && (w_sum[C-1:0] == '0);
  assign w_ovf  = (in_a[HI] == in_b[HI]) && (w_sum[C-1] != in_a[HI]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else if (en) begin
      r_valid <= in_valid;
      r_carry <= w_sum[C];
      r_zero  <= w_zero;
      r_ovf   <= w_ovf;
      r_a     <= in_a;
      r_b     <= in_b;
      r_res   <= w_res;
    end
  end

  assign out_valid = r_valid;
  assign out_carry = r_carry;
  assign out_zero  = r_zero;
  assign out_ovf   = r_ovf;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_res   = r_res;

endmodule

`default_nettype wire

// File: rtl/pipelined_addsub.sv
// ============================================================================
// Module   : pipelined_addsub
// Brief    : Carry-split pipelined adder/subtractor with flags and backpressure.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  generate
    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES, with STAGES in 1..8");
    end
  endgenerate

  logic             w_adv;
  logic             w_valid [STAGES+1];
  logic             w_carry [STAGES+1];
  logic             w_zero  [STAGES+1];
  logic             w_ovf   [STAGES];
  logic [WIDTH-1:0] w_a     [STAGES+1];
  logic [WIDTH-1:0] w_b     [STAGES+1];
  logic [WIDTH-1:0] w_res   [STAGES+1];

  // One shared enable: the whole pipe either shifts or freezes as a unit.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_carry[0] = (sub == ADDSUB_SUB);
  assign w_zero[0]  = 1'b1;
  assign w_a[0]     = input1;
  assign w_b[0]     = (sub == ADDSUB_ADD) ? input2 : ~input2;
  assign w_res[0]   = '0;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      addsub_slice #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .IDX    (k)
      ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .en        (w_adv),
        .in_valid  (w_valid[k]),
        .in_carry  (w_carry[k]),
        .in_zero   (w_zero[k]),
        .in_a      (w_a[k]),
        .in_b      (w_b[k]),
        .in_res    (w_res[k]),
        .out_valid (w_valid[k+1]),
        .out_carry (w_carry[k+1]),
        .out_zero  (w_zero[k+1]),
        .out_ovf   (w_ovf[k]),
        .out_a     (w_a[k+1]),
        .out_b     (w_b[k+1]),
        .out_res   (w_res[k+1])
      );
    end
  endgenerate

  assign out_valid = w_valid[STAGES];
  assign out       = w_res[STAGES];
  assign carry_out = w_carry[STAGES];
  assign zero      = w_zero[STAGES];
  assign overflow  = w_ovf[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
// ============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Directed and randomized checks of pipelined_addsub against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_addsub;

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    exp_t e;
    int   age;
  } flight_t;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result defined arithmetically: add/sub modulo 2^w, carry = no-borrow for sub.
  function automatic exp_t ref_op(input int w, input logic s, input logic [63:0] a,
                                  input logic [63:0] b);
    exp_t        r;
    logic [64:0] full;
    logic [63:0] m;
    m = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - w);
    if (!s) begin
      full  = {1'b0, a} + {1'b0, b};
      r.res = full[63:0] & m;
      r.c   = full[w];
      r.v   = (a[w-1] == b[w-1]) && (r.res[w-1] != a[w-1]);
    end else begin
      full  = '0;
      r.res = (a - b) & m;
      r.c   = (a >= b);
      r.v   = (a[w-1] != b[w-1]) && (r.res[w-1] != a[w-1]);
    end
    r.z = (r.res == 64'd0);
    return r;
  endfunction

  // ---------------- default configuration, directed tests ----------------
  logic        d_rst, d_in_valid, d_in_ready, d_sub, d_out_valid, d_out_ready;
  logic        d_carry, d_ovf, d_zero;
  logic [31:0] d_a, d_b, d_out;

  pipelined_addsub dut (
    .clk       (clk),
    .rst       (d_rst),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .sub       (d_sub),
    .input1    (d_a),
    .input2    (d_b),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out       (d_out),
    .carry_out (d_carry),
    .overflow  (d_ovf),
    .zero      (d_zero)
  );

  task automatic put(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
    d_in_valid = v;
    d_sub      = s;
    d_a        = a;
    d_b        = b;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] r, input logic c,
                            input logic v, input logic z);
    check({tag, " valid"}, d_out_valid, 1);
    check({tag, " out"}, d_out, r);
    check({tag, " carry"}, d_carry, c);
    check({tag, " ovf"}, d_ovf, v);
    check({tag, " zero"}, d_zero, z);
  endtask

  localparam int NV = 8;
  vec_t tbl [NV];

  initial begin
    tbl[0] = '{1'b0, 32'd0,          32'd10,    32'd10,        1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'd1000,       32'd10,    32'd1010,      1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'd12345,      32'd54321, 32'd66666,     1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'd5,          32'd7,     32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'd7,          32'd7,     32'd0,         1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h7FFF_FFFF,  32'd1,     32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,     32'd0,         1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 32'h8000_0000,  32'd1,     32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};

    d_rst = 1'b1; d_out_ready = 1'b1;
    put(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("rst out_valid", d_out_valid, 0);
    check("rst out", d_out, 0);
    check("rst carry", d_carry, 0);
    check("rst ovf", d_ovf, 0);
    check("rst zero", d_zero, 0);
    check("rst in_ready", d_in_ready, 1);
    d_rst = 1'b0;

    // Back-to-back stream: op i is visible two edges after it is presented.
    for (int i = 0; i < NV + 3; i++) begin
      @(negedge clk);
      if (i >= 2 && i - 2 < NV)
        expect_res($sformatf("tbl%0d", i - 2), tbl[i-2].res, tbl[i-2].c, tbl[i-2].v, tbl[i-2].z);
      else
        check($sformatf("tbl idle%0d valid", i), d_out_valid, 0);
      if (i < NV) put(1'b1, tbl[i].s, tbl[i].a, tbl[i].b);
      else        put(1'b0, 1'b0, 32'd0, 32'd0);
    end

    // Backpressure: stall four cycles on the first result.
    @(negedge clk); put(1'b1, 1'b0, 32'd11, 32'd1);
    @(negedge clk); check("bp pre valid", d_out_valid, 0); put(1'b1, 1'b0, 32'd22, 32'd2);
    @(negedge clk); expect_res("bp first", 32'd12, 1'b0, 1'b0, 1'b0);
    put(1'b1, 1'b0, 32'd33, 32'd3); d_out_ready = 1'b0;
    #1 check("bp in_ready", d_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_res($sformatf("bp hold%0d", i), 32'd12, 1'b0, 1'b0, 1'b0);
      check($sformatf("bp hold%0d in_ready", i), d_in_ready, 0);
    end
    @(negedge clk); expect_res("bp last hold", 32'd12, 1'b0, 1'b0, 1'b0);
    d_out_ready = 1'b1;
    #1 check("bp release in_ready", d_in_ready, 1);
    @(negedge clk); expect_res("bp second", 32'd24, 1'b0, 1'b0, 1'b0); put(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); expect_res("bp third", 32'd36, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("bp drained valid", d_out_valid, 0);

    // Reset mid-flight: the second op must never appear.
    @(negedge clk); put(1'b1, 1'b0, 32'd100, 32'd1);
    @(negedge clk); put(1'b1, 1'b0, 32'd200, 32'd2);
    @(negedge clk); expect_res("mr first", 32'd101, 1'b0, 1'b0, 1'b0);
    d_rst = 1'b1; put(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("mr rst valid", d_out_valid, 0);
    check("mr rst out", d_out, 0);
    check("mr rst zero", d_zero, 0);
    d_rst = 1'b0; put(1'b1, 1'b0, 32'd3, 32'd4);
    @(negedge clk); check("mr no stale", d_out_valid, 0); put(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); expect_res("mr new", 32'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("mr after valid", d_out_valid, 0);

    for (int t = 0; t < 3000; t++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
      @(negedge clk);
    end
    check("sweep done", {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}, 3'b111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- parameter sweep, randomized against the model ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 8 : 64;
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

    logic         rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic         carry_out, overflow, zero;
    logic [W-1:0] in1, in2, out;
    logic         done;
    flight_t      q[$];

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sub       (sub),
      .input1    (in1),
      .input2    (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
    );

    function automatic logic [63:0] pick();
      logic [63:0] m;
      m = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - W);
      case ($urandom_range(0, 7))
        0:       return 64'd0;
        1:       return m;
        2:       return m >> 1;
        3:       return (m >> 1) + 64'd1;
        default: return {$urandom, $urandom} & m;
      endcase
    endfunction

    initial begin
      logic        ev, iv, rdy, sv;
      logic [63:0] pa, pb;
      flight_t     f;
      done = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      sub = 1'b0; in1 = '0; in2 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].age == S);
        check($sformatf("sw%0d valid c%0d", g, cyc), out_valid, ev);
        if (ev) begin
          check($sformatf("sw%0d out c%0d", g, cyc), out, q[0].e.res);
          check($sformatf("sw%0d carry c%0d", g, cyc), carry_out, q[0].e.c);
          check($sformatf("sw%0d ovf c%0d", g, cyc), overflow, q[0].e.v);
          check($sformatf("sw%0d zero c%0d", g, cyc), zero, q[0].e.z);
        end
        iv  = (cyc < 560) ? ($urandom_range(0, 3) != 0) : 1'b0;
        rdy = (cyc < 560) ? ($urandom_range(0, 3) != 0) : 1'b1;
        sv  = $urandom_range(0, 1) == 1;
        pa  = pick();
        pb  = pick();
        in_valid = iv; out_ready = rdy; sub = sv;
        in1 = pa[W-1:0]; in2 = pb[W-1:0];
        #1 check($sformatf("sw%0d in_ready c%0d", g, cyc), in_ready, !ev || rdy);
        if (!ev || rdy) begin
          if (ev) void'(q.pop_front());
          foreach (q[j]) q[j].age++;
          if (iv) begin
            f.e   = ref_op(W, sv, pa, pb);
            f.age = 1;
            q.push_back(f);
          end
        end
      end
      check($sformatf("sw%0d leftover", g), q.size(), 0);
      done = 1'b1;
    end
  end

endmodule

`default_nettype wire
